// File: rtl/brdg_pkg.sv
// Shared TLX command-channel definitions for the bridge: field widths, opcodes,
// the command payload struct and the credit FSM encoding.
package brdg_pkg;

    localparam int unsigned OPC_W      = 8;
    localparam int unsigned AFUTAG_W   = 16;
    localparam int unsigned EA_W       = 68;
    localparam int unsigned DL_W       = 2;
    localparam int unsigned PL_W       = 3;
    localparam int unsigned ACTAG_W    = 12;
    localparam int unsigned PASID_W    = 20;
    localparam int unsigned INIT_CRD_W = 4;

    localparam logic [OPC_W-1:0] OPC_NOP       = 8'h00;
    localparam logic [OPC_W-1:0] OPC_RD_WNITC  = 8'h10;
    localparam logic [OPC_W-1:0] OPC_DMA_W     = 8'h20;
    localparam logic [OPC_W-1:0] OPC_INTRP_REQ = 8'h58;

    typedef struct packed {
        logic [OPC_W-1:0]    opcode;
        logic [AFUTAG_W-1:0] afutag;
        logic [EA_W-1:0]     ea_or_obj;
        logic [DL_W-1:0]     dl;
        logic [PL_W-1:0]     pl;
        logic [ACTAG_W-1:0]  actag;
        logic [PASID_W-1:0]  pasid;
    } tlx_cmd_t;

    typedef enum logic [1:0] {
        CRD_INIT = 2'd0,
        CRD_LOAD = 2'd1,
        CRD_RUN  = 2'd2
    } crd_state_t;

endpackage

// File: rtl/brdg_cmd_credit.sv
// TLX command-credit tracker: loads the initial credit after reset, then counts
// returns against issued commands and flags overflow/underflow stickily.
module brdg_cmd_credit
    import brdg_pkg::*;
#(
    parameter int unsigned CRDW = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tlx_o_cmd_valid_mon,
    input  logic [INIT_CRD_W-1:0] tlx_afu_cmd_initial_credit,
    input  logic                  tlx_afu_cmd_credit,
    output logic                  tlx_afu_cmd_ready,
    output logic [CRDW-1:0]       crd_cnt,
    output logic                  crd_err
);

    localparam logic [CRDW-1:0] CRD_MAX = '1;

    crd_state_t      state_q, state_d;
    logic [CRDW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CRD_INIT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            CRD_INIT: state_d = CRD_LOAD;
            CRD_LOAD: begin
                cnt_d   = CRDW'(tlx_afu_cmd_initial_credit);
                state_d = CRD_RUN;
            end
            CRD_RUN: begin
                // A return and a consume in the same cycle cancel out.
                if (tlx_afu_cmd_credit && !tlx_o_cmd_valid_mon) begin
                    if (cnt_q == CRD_MAX) err_d = 1'b1;
                    else                  cnt_d = cnt_q + CRDW'(1);
                end else if (!tlx_afu_cmd_credit && tlx_o_cmd_valid_mon) begin
                    if (cnt_q == '0) err_d = 1'b1;
                    else             cnt_d = cnt_q - CRDW'(1);
                end
            end
            default: state_d = CRD_INIT;
        endcase
    end

    // Reserve the credit of a command leaving this cycle so issue never overdraws.
    assign tlx_afu_cmd_ready = (state_q == CRD_RUN) && (cnt_q > CRDW'(tlx_o_cmd_valid_mon));
    assign crd_cnt           = cnt_q;
    assign crd_err           = err_q;

endmodule

// File: rtl/brdg_cmd_arbiter.sv
// Merges write/read/interrupt command requesters onto the single TLX command
// path through a registered output stage, and hosts the command-credit tracker.
module brdg_cmd_arbiter
    import brdg_pkg::*;
#(
    parameter int unsigned CRDW = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_cmd_valid,
    output logic                  wr_cmd_ready,
    input  logic [OPC_W-1:0]      wr_cmd_opcode,
    input  logic [AFUTAG_W-1:0]   wr_cmd_afutag,
    input  logic [EA_W-1:0]       wr_cmd_ea_or_obj,
    input  logic [DL_W-1:0]       wr_cmd_dl,
    input  logic [PL_W-1:0]       wr_cmd_pl,
    input  logic [ACTAG_W-1:0]    wr_cmd_actag,
    input  logic [PASID_W-1:0]    wr_cmd_pasid,
    input  logic                  rd_cmd_valid,
    output logic                  rd_cmd_ready,
    input  logic [OPC_W-1:0]      rd_cmd_opcode,
    input  logic [AFUTAG_W-1:0]   rd_cmd_afutag,
    input  logic [EA_W-1:0]       rd_cmd_ea_or_obj,
    input  logic [DL_W-1:0]       rd_cmd_dl,
    input  logic [PL_W-1:0]       rd_cmd_pl,
    input  logic [ACTAG_W-1:0]    rd_cmd_actag,
    input  logic [PASID_W-1:0]    rd_cmd_pasid,
    input  logic                  ir_cmd_valid,
    output logic                  ir_cmd_ready,
    input  logic [OPC_W-1:0]      ir_cmd_opcode,
    input  logic [AFUTAG_W-1:0]   ir_cmd_afutag,
    input  logic [EA_W-1:0]       ir_cmd_ea_or_obj,
    input  logic [DL_W-1:0]       ir_cmd_dl,
    input  logic [PL_W-1:0]       ir_cmd_pl,
    input  logic [ACTAG_W-1:0]    ir_cmd_actag,
    input  logic [PASID_W-1:0]    ir_cmd_pasid,
    output logic                  arb_o_cmd_valid,
    output logic [OPC_W-1:0]      arb_o_cmd_opcode,
    output logic [AFUTAG_W-1:0]   arb_o_cmd_afutag,
    output logic [EA_W-1:0]       arb_o_cmd_ea_or_obj,
    output logic [DL_W-1:0]       arb_o_cmd_dl,
    output logic [PL_W-1:0]       arb_o_cmd_pl,
    output logic [ACTAG_W-1:0]    arb_o_cmd_actag,
    output logic [PASID_W-1:0]    arb_o_cmd_pasid,
    input  logic                  arb_i_cmd_ready,
    input  logic                  tlx_o_cmd_valid_mon,
    input  logic [INIT_CRD_W-1:0] tlx_afu_cmd_initial_credit,
    input  logic                  tlx_afu_cmd_credit,
    output logic                  tlx_afu_cmd_ready,
    output logic [CRDW-1:0]       crd_cnt,
    output logic                  crd_err
);

    tlx_cmd_t wr_cmd, rd_cmd, ir_cmd;
    tlx_cmd_t out_q, out_d;
    logic     out_vld_q, out_vld_d;
    logic     rr_q, rr_d;
    logic     arb_en_q;
    logic     load;
    logic     gnt_wr, gnt_rd, gnt_ir;

    assign wr_cmd = '{opcode: wr_cmd_opcode, afutag: wr_cmd_afutag, ea_or_obj: wr_cmd_ea_or_obj,
                      dl: wr_cmd_dl, pl: wr_cmd_pl, actag: wr_cmd_actag, pasid: wr_cmd_pasid};
    assign rd_cmd = '{opcode: rd_cmd_opcode, afutag: rd_cmd_afutag, ea_or_obj: rd_cmd_ea_or_obj,
                      dl: rd_cmd_dl, pl: rd_cmd_pl, actag: rd_cmd_actag, pasid: rd_cmd_pasid};
    assign ir_cmd = '{opcode: ir_cmd_opcode, afutag: ir_cmd_afutag, ea_or_obj: ir_cmd_ea_or_obj,
                      dl: ir_cmd_dl, pl: ir_cmd_pl, actag: ir_cmd_actag, pasid: ir_cmd_pasid};

    // arb_en_q keeps every requester ready low while reset is applied.
    assign load = arb_en_q && (!out_vld_q || arb_i_cmd_ready);

    // Interrupts win outright; wr/rd alternate via rr (0 = wr preferred).
    always_comb begin
        gnt_wr    = 1'b0;
        gnt_rd    = 1'b0;
        gnt_ir    = 1'b0;
        rr_d      = rr_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (load) begin
            out_vld_d = 1'b0;
            if (ir_cmd_valid) begin
                gnt_ir    = 1'b1;
                out_d     = ir_cmd;
                out_vld_d = 1'b1;
            end else if (wr_cmd_valid && (!rd_cmd_valid || !rr_q)) begin
                gnt_wr    = 1'b1;
                out_d     = wr_cmd;
                out_vld_d = 1'b1;
                rr_d      = 1'b1;
            end else if (rd_cmd_valid) begin
                gnt_rd    = 1'b1;
                out_d     = rd_cmd;
                out_vld_d = 1'b1;
                rr_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
            rr_q      <= 1'b0;
            arb_en_q  <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            rr_q      <= rr_d;
            arb_en_q  <= 1'b1;
        end
    end

    assign wr_cmd_ready        = gnt_wr;
    assign rd_cmd_ready        = gnt_rd;
    assign ir_cmd_ready        = gnt_ir;
    assign arb_o_cmd_valid     = out_vld_q;
    assign arb_o_cmd_opcode    = out_q.opcode;
    assign arb_o_cmd_afutag    = out_q.afutag;
    assign arb_o_cmd_ea_or_obj = out_q.ea_or_obj;
    assign arb_o_cmd_dl        = out_q.dl;
    assign arb_o_cmd_pl        = out_q.pl;
    assign arb_o_cmd_actag     = out_q.actag;
    assign arb_o_cmd_pasid     = out_q.pasid;

    brdg_cmd_credit #(
        .CRDW(CRDW)
    ) u_credit (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .tlx_o_cmd_valid_mon        (tlx_o_cmd_valid_mon),
        .tlx_afu_cmd_initial_credit (tlx_afu_cmd_initial_credit),
        .tlx_afu_cmd_credit         (tlx_afu_cmd_credit),
        .tlx_afu_cmd_ready          (tlx_afu_cmd_ready),
        .crd_cnt                    (crd_cnt),
        .crd_err                    (crd_err)
    );

endmodule

// File: tb/tb_brdg_cmd_arbiter.sv
// Directed bench for brdg_cmd_arbiter: credit bring-up, wr/rd/ir arbitration,
// back-pressure hold, credit saturation and mid-operation reset.
module tb_brdg_cmd_arbiter;
    import brdg_pkg::*;

    localparam int unsigned CRDW = 6;

    logic clk, rst_n;
    logic wr_cmd_valid, wr_cmd_ready, rd_cmd_valid, rd_cmd_ready, ir_cmd_valid, ir_cmd_ready;
    logic [7:0]  wr_cmd_opcode, rd_cmd_opcode, ir_cmd_opcode;
    logic [15:0] wr_cmd_afutag, rd_cmd_afutag, ir_cmd_afutag;
    logic [67:0] wr_cmd_ea_or_obj, rd_cmd_ea_or_obj, ir_cmd_ea_or_obj;
    logic [1:0]  wr_cmd_dl, rd_cmd_dl, ir_cmd_dl;
    logic [2:0]  wr_cmd_pl, rd_cmd_pl, ir_cmd_pl;
    logic [11:0] wr_cmd_actag, rd_cmd_actag, ir_cmd_actag;
    logic [19:0] wr_cmd_pasid, rd_cmd_pasid, ir_cmd_pasid;
    logic        arb_o_cmd_valid;
    logic [7:0]  arb_o_cmd_opcode;
    logic [15:0] arb_o_cmd_afutag;
    logic [67:0] arb_o_cmd_ea_or_obj;
    logic [1:0]  arb_o_cmd_dl;
    logic [2:0]  arb_o_cmd_pl;
    logic [11:0] arb_o_cmd_actag;
    logic [19:0] arb_o_cmd_pasid;
    logic        arb_i_cmd_ready, tlx_o_cmd_valid_mon, tlx_afu_cmd_credit, tlx_afu_cmd_ready;
    logic [3:0]  tlx_afu_cmd_initial_credit;
    logic [CRDW-1:0] crd_cnt;
    logic        crd_err;

    int n_asrt = 0;
    int n_fail = 0;

    brdg_cmd_arbiter #(.CRDW(CRDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_opcode(wr_cmd_opcode),
        .wr_cmd_afutag(wr_cmd_afutag), .wr_cmd_ea_or_obj(wr_cmd_ea_or_obj), .wr_cmd_dl(wr_cmd_dl),
        .wr_cmd_pl(wr_cmd_pl), .wr_cmd_actag(wr_cmd_actag), .wr_cmd_pasid(wr_cmd_pasid),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_opcode(rd_cmd_opcode),
        .rd_cmd_afutag(rd_cmd_afutag), .rd_cmd_ea_or_obj(rd_cmd_ea_or_obj), .rd_cmd_dl(rd_cmd_dl),
        .rd_cmd_pl(rd_cmd_pl), .rd_cmd_actag(rd_cmd_actag), .rd_cmd_pasid(rd_cmd_pasid),
        .ir_cmd_valid(ir_cmd_valid), .ir_cmd_ready(ir_cmd_ready), .ir_cmd_opcode(ir_cmd_opcode),
        .ir_cmd_afutag(ir_cmd_afutag), .ir_cmd_ea_or_obj(ir_cmd_ea_or_obj), .ir_cmd_dl(ir_cmd_dl),
        .ir_cmd_pl(ir_cmd_pl), .ir_cmd_actag(ir_cmd_actag), .ir_cmd_pasid(ir_cmd_pasid),
        .arb_o_cmd_valid(arb_o_cmd_valid), .arb_o_cmd_opcode(arb_o_cmd_opcode),
        .arb_o_cmd_afutag(arb_o_cmd_afutag), .arb_o_cmd_ea_or_obj(arb_o_cmd_ea_or_obj),
        .arb_o_cmd_dl(arb_o_cmd_dl), .arb_o_cmd_pl(arb_o_cmd_pl),
        .arb_o_cmd_actag(arb_o_cmd_actag), .arb_o_cmd_pasid(arb_o_cmd_pasid),
        .arb_i_cmd_ready(arb_i_cmd_ready), .tlx_o_cmd_valid_mon(tlx_o_cmd_valid_mon),
        .tlx_afu_cmd_initial_credit(tlx_afu_cmd_initial_credit),
        .tlx_afu_cmd_credit(tlx_afu_cmd_credit), .tlx_afu_cmd_ready(tlx_afu_cmd_ready),
        .crd_cnt(crd_cnt), .crd_err(crd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the three requester readies against a one-hot {ir,rd,wr} pattern.
    task automatic chk_rdy(input string tag, input logic [2:0] exp);
        chk(tag, 128'({ir_cmd_ready, rd_cmd_ready, wr_cmd_ready}), 128'(exp));
    endtask

    initial begin
        logic [7:0]  exp_op [8];
        logic [2:0]  exp_g  [8];
        logic [2:0]  grant_seq;

        rst_n = 1'b0;
        wr_cmd_valid = 1'b1; rd_cmd_valid = 1'b0; ir_cmd_valid = 1'b0;
        wr_cmd_opcode = OPC_DMA_W;     wr_cmd_afutag = 16'h1111; wr_cmd_ea_or_obj = 68'hA_0000_0000_0000_1000;
        wr_cmd_dl = 2'd1; wr_cmd_pl = 3'd0; wr_cmd_actag = 12'h0A1; wr_cmd_pasid = 20'h00011;
        rd_cmd_opcode = OPC_RD_WNITC;  rd_cmd_afutag = 16'h2222; rd_cmd_ea_or_obj = 68'hB_0000_0000_0000_2000;
        rd_cmd_dl = 2'd2; rd_cmd_pl = 3'd0; rd_cmd_actag = 12'h0B2; rd_cmd_pasid = 20'h00022;
        ir_cmd_opcode = OPC_INTRP_REQ; ir_cmd_afutag = 16'h3333; ir_cmd_ea_or_obj = 68'hC_0000_0000_0000_3000;
        ir_cmd_dl = 2'd0; ir_cmd_pl = 3'd3; ir_cmd_actag = 12'h0C3; ir_cmd_pasid = 20'h00033;
        arb_i_cmd_ready = 1'b0; tlx_o_cmd_valid_mon = 1'b0; tlx_afu_cmd_credit = 1'b0;
        tlx_afu_cmd_initial_credit = 4'd4;

        // Reset state, with a requester already valid
        tick(); tick();
        chk("rst_rdy", 128'({ir_cmd_ready, rd_cmd_ready, wr_cmd_ready}), 128'(0));
        chk("rst_out_valid", 128'(arb_o_cmd_valid), 128'(0));
        chk("rst_out_opcode", 128'(arb_o_cmd_opcode), 128'(0));
        chk("rst_crd_cnt", 128'(crd_cnt), 128'(0));
        chk("rst_crd_err", 128'(crd_err), 128'(0));
        chk("rst_tlx_rdy", 128'(tlx_afu_cmd_ready), 128'(0));
        wr_cmd_valid = 1'b0;

        // Bring-up: INIT, LOAD, RUN
        @(negedge clk); rst_n = 1'b1; #1;
        chk("init_tlx_rdy", 128'(tlx_afu_cmd_ready), 128'(0));
        tick();
        chk("load_tlx_rdy", 128'(tlx_afu_cmd_ready), 128'(0));
        tick();
        chk("run_tlx_rdy", 128'(tlx_afu_cmd_ready), 128'(1));
        chk("run_crd_cnt", 128'(crd_cnt), 128'(4));

        // Four consumes; ready drops while the fourth issues
        tlx_o_cmd_valid_mon = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("consume%0d_tlx_rdy", i), 128'(tlx_afu_cmd_ready), 128'(i < 3 ? 1 : 0));
            tick();
            chk($sformatf("consume%0d_cnt", i), 128'(crd_cnt), 128'(3 - i));
        end
        tlx_o_cmd_valid_mon = 1'b0; #1;
        chk("empty_tlx_rdy", 128'(tlx_afu_cmd_ready), 128'(0));
        chk("empty_err", 128'(crd_err), 128'(0));

        // Two returns, then return + consume together
        tlx_afu_cmd_credit = 1'b1;
        tick();
        chk("ret1_cnt", 128'(crd_cnt), 128'(1));
        chk("ret1_tlx_rdy", 128'(tlx_afu_cmd_ready), 128'(1));
        tick();
        chk("ret2_cnt", 128'(crd_cnt), 128'(2));
        tlx_o_cmd_valid_mon = 1'b1;
        tick();
        chk("ret_and_consume_cnt", 128'(crd_cnt), 128'(2));
        tlx_o_cmd_valid_mon = 1'b0;

        // Fill to 63, then one more return saturates and flags
        for (int i = 0; i < 61; i++) tick();
        chk("full_cnt", 128'(crd_cnt), 128'(63));
        chk("full_err", 128'(crd_err), 128'(0));
        tick();
        chk("ovf_cnt", 128'(crd_cnt), 128'(63));
        chk("ovf_err", 128'(crd_err), 128'(1));
        tlx_afu_cmd_credit = 1'b0;
        tick();
        chk("ovf_err_sticky", 128'(crd_err), 128'(1));

        // Contention: wr, rd, wr, rd, wr, then ir (rr left pointing at rd), rd, wr
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b001; exp_g[3] = 3'b010;
        exp_g[4] = 3'b001; exp_g[5] = 3'b100; exp_g[6] = 3'b010; exp_g[7] = 3'b001;
        exp_op[0] = 8'h20; exp_op[1] = 8'h10; exp_op[2] = 8'h20; exp_op[3] = 8'h10;
        exp_op[4] = 8'h20; exp_op[5] = 8'h58; exp_op[6] = 8'h10; exp_op[7] = 8'h20;
        arb_i_cmd_ready = 1'b1; wr_cmd_valid = 1'b1; rd_cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ir_cmd_valid = (i == 5);
            #1;
            grant_seq = exp_g[i];
            chk_rdy($sformatf("arb%0d_rdy", i), grant_seq);
            tick();
            chk($sformatf("arb%0d_valid", i), 128'(arb_o_cmd_valid), 128'(1));
            chk($sformatf("arb%0d_opcode", i), 128'(arb_o_cmd_opcode), 128'(exp_op[i]));
        end
        ir_cmd_valid = 1'b0;
        chk("arb_last_afutag", 128'(arb_o_cmd_afutag), 128'(16'h1111));
        chk("arb_last_ea", 128'(arb_o_cmd_ea_or_obj), 128'(68'hA_0000_0000_0000_1000));

        // Back-pressure: output holds and nobody is granted
        arb_i_cmd_ready = 1'b0; ir_cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_rdy($sformatf("stall%0d_rdy", i), 3'b000);
            tick();
            chk($sformatf("stall%0d_valid", i), 128'(arb_o_cmd_valid), 128'(1));
            chk($sformatf("stall%0d_afutag", i), 128'(arb_o_cmd_afutag), 128'(16'h1111));
        end
        chk("stall_pasid", 128'(arb_o_cmd_pasid), 128'(20'h00011));

        // Acceptance with no requesters clears valid
        wr_cmd_valid = 1'b0; rd_cmd_valid = 1'b0; ir_cmd_valid = 1'b0; arb_i_cmd_ready = 1'b1;
        tick();
        chk("drain_valid", 128'(arb_o_cmd_valid), 128'(0));

        // Reset while a command is held
        arb_i_cmd_ready = 1'b0; rd_cmd_valid = 1'b1;
        tick();
        chk("held_valid", 128'(arb_o_cmd_valid), 128'(1));
        chk("held_opcode", 128'(arb_o_cmd_opcode), 128'(8'h10));
        rd_cmd_valid = 1'b0;
        tlx_afu_cmd_initial_credit = 4'd3;
        rst_n = 1'b0; #1;
        chk("midrst_valid", 128'(arb_o_cmd_valid), 128'(0));
        chk("midrst_cnt", 128'(crd_cnt), 128'(0));
        chk("midrst_err", 128'(crd_err), 128'(0));
        chk("midrst_tlx_rdy", 128'(tlx_afu_cmd_ready), 128'(0));
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();
        chk("reload_cnt", 128'(crd_cnt), 128'(3));
        chk("reload_tlx_rdy", 128'(tlx_afu_cmd_ready), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
